// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Execute forwarding selects, load-use/branch/mult-div stalls and the mult/div busy/done sequencer.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall_cnt output.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MdStartE,
  input  logic       MdOpE,
  input  logic       MdUseD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [5:0] MULT_L = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_L  = 6'(DIV_CYCLES - 1);
  state_t     state;
  logic [5:0] cnt;
  logic       lwstall, brstall, mdstall, stall;
  function automatic logic [1:0] fwd(input logic [4:0] r);
    return (r != 5'd0 && RegWriteM && WriteRegM == r) ? 2'b10 :
           (r != 5'd0 && RegWriteW && WriteRegW == r) ? 2'b01 : 2'b00;
  endfunction
  function automatic logic br_hit(input logic [4:0] s);
    return s != 5'd0 && ((RegWriteE && WriteRegE == s) || (MemtoRegM && WriteRegM == s));
  endfunction
  assign lwstall   = MemtoRegE && RtE != 5'd0 && (RtE == RsD || RtE == RtD);
  assign brstall   = BranchD && (br_hit(RsD) || br_hit(RtD));
  assign mdstall   = MdUseD && state == BUSY;
  assign stall     = reset_n && (lwstall || brstall || mdstall);
  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushE    = stall;
  assign ForwardAE = reset_n ? fwd(RsE) : 2'b00;
  assign ForwardBE = reset_n ? fwd(RtE) : 2'b00;
  assign md_busy   = reset_n && state == BUSY;
  assign md_done   = reset_n && state == DONE;
  // DONE shares IDLE's issue path so a new op can start back-to-back
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == BUSY) begin
      if (cnt == 6'd0) state <= DONE;
      else cnt <= cnt - 6'd1;
    end else if (MdStartE) begin
      state <= BUSY;
      cnt   <= MdOpE ? DIV_L : MULT_L;
    end else state <= IDLE;
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule
